// File: rtl/cycle_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | cycle_sequencer_pkg : shared control-unit state and T-state constants  |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
`default_nettype none

package cycle_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STOP = 2'd2
  } seq_state_t;

  localparam logic [3:0] T1_STEP   = 4'b0001;
  localparam logic [3:0] T2_STEP   = 4'b0010;
  localparam logic [3:0] T3_STEP   = 4'b0100;
  localparam logic [3:0] T4_STEP   = 4'b1000;
  localparam logic [3:0] STEP_NONE = 4'b0000;

endpackage

`default_nettype wire

// File: rtl/cycle_sequencer_tstate_ring.sv
// +----------------------------------------------------------------------+
// | tstate_ring : 4-bit one-hot T-state rotator with restart, clear, hold |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tstate_ring
  import cycle_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       restart,
  input  logic       clear,
  input  logic       hold,
  output logic [3:0] step
);

  // restart beats clear beats hold
  always_ff @(posedge clk) begin
    if (restart) begin
      step <= T1_STEP;
    end else if (clear) begin
      step <= STEP_NONE;
    end else if (!hold) begin
      step <= {step[2:0], step[3]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/cycle_sequencer.sv
// +----------------------------------------------------------------------+
// | cycle_sequencer : T-state / M-cycle sequencer with HALT and STOP modes |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int MAX_MCYCLES = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Fetch,
  input  logic                   i_Halt,
  input  logic                   i_Stop,
  input  logic                   i_Wake,
  input  logic                   i_Wait,
  output logic [3:0]             o_Cycle_Step,
  output logic [MAX_MCYCLES-1:0] o_Cycle_Count,
  output logic                   o_IR_Load,
  output logic                   o_Instr_Start,
  output logic                   o_Halted,
  output logic                   o_Stopped,
  output logic                   o_Fault
);

  localparam logic [MAX_MCYCLES-1:0] M1 = {{(MAX_MCYCLES-1){1'b0}}, 1'b1};

  seq_state_t             state;
  seq_state_t             next_state;
  logic [MAX_MCYCLES-1:0] count;
  logic [MAX_MCYCLES-1:0] next_count;
  logic                   fault;
  logic                   fault_set;
  logic                   ir_load;
  logic                   instr_start;
  logic                   start_next;
  logic                   ring_restart;
  logic                   ring_clear;
  logic                   ring_hold;
  logic                   at_t4;

  tstate_ring u_ring (
    .clk     (i_Clk),
    .restart (ring_restart),
    .clear   (ring_clear),
    .hold    (ring_hold),
    .step    (o_Cycle_Step)
  );

  assign at_t4 = (o_Cycle_Step == T4_STEP) && !i_Wait;

  always_comb begin
    next_state   = state;
    next_count   = count;
    fault_set    = 1'b0;
    ir_load      = 1'b0;
    start_next   = 1'b0;
    ring_restart = i_Reset;
    ring_clear   = 1'b0;
    ring_hold    = i_Wait;
    case (state)
      ST_RUN: begin
        if (at_t4) begin
          if (i_Fetch) begin
            ir_load    = 1'b1;
            next_count = M1;
            if (i_Stop) begin
              next_state = ST_STOP;
            end else if (i_Halt) begin
              next_state = ST_HALT;
            end
          end else if (count[MAX_MCYCLES-1]) begin
            // runaway instruction: force a refetch and remember it
            fault_set  = 1'b1;
            ir_load    = 1'b1;
            next_count = M1;
          end else begin
            next_count = count << 1;
          end
          start_next = ir_load && (next_state == ST_RUN);
          ring_clear = (next_state == ST_STOP);
        end
      end
      ST_HALT: begin
        if (at_t4 && i_Wake) begin
          next_state = ST_RUN;
          start_next = 1'b1;
        end
      end
      ST_STOP: begin
        ring_hold = 1'b0;
        if (i_Wake) begin
          next_state   = ST_RUN;
          ring_restart = 1'b1;
        end else begin
          ring_clear = 1'b1;
        end
      end
      default: begin
        next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= ST_RUN;
      count       <= M1;
      fault       <= 1'b0;
      instr_start <= 1'b1;
    end else begin
      state       <= next_state;
      count       <= next_count;
      fault       <= fault | fault_set;
      instr_start <= start_next;
    end
  end

  assign o_Cycle_Count = count;
  assign o_IR_Load     = ir_load && !i_Reset;
  assign o_Instr_Start = instr_start;
  assign o_Halted      = (state == ST_HALT);
  assign o_Stopped     = (state == ST_STOP);
  assign o_Fault       = fault;

endmodule

`default_nettype wire
